// File: rtl/col_parity_pkg.sv
// Shared types and constants for the column parity checker.
// Slices are 5x5 bit planes; row 0 / col 0 sits in the MSB.
package col_parity_pkg;

  localparam int NUM_SLICES_DEF = 64;
  localparam int ROWS           = 5;
  localparam int COLS           = 5;
  localparam int SLICE_W        = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int bidx(input int row, input int col);
    return SLICE_W - 1 - (COLS * row + col);
  endfunction

endpackage

// File: rtl/col_parity_vec.sv
// Column parity of one 25-bit slice.
// Bit c of the result is the parity of column c.
module col_parity_vec
  import col_parity_pkg::*;
(
  input  logic [SLICE_W-1:0] i_slice,
  output logic [COLS-1:0]    o_par
);

  always_comb begin
    o_par = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        o_par[c] = o_par[c] ^ i_slice[bidx(r, c)];
      end
    end
  end

endmodule

// File: rtl/col_parity_checker.sv
// Checks a stream of column-parity-transformed slices against
// a locally recomputed expectation, reporting per-slice diffs.
module col_parity_checker
  import col_parity_pkg::*;
#(
  parameter int NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [24:0]  slice_in,
  input  logic [24:0]  slice_out,
  output logic         err_valid,
  output logic [24:0]  err_mask,
  output logic [5:0]   slice_idx,
  output logic         done,
  output logic         pass,
  output logic [6:0]   err_count
);

  localparam logic [5:0] LAST = 6'(NUM_SLICES - 1);

  state_t       r_state;
  state_t       w_next;
  logic [5:0]   r_cnt;
  logic [4:0]   r_p;
  logic [4:0]   w_c;
  logic [24:0]  w_exp;
  logic [24:0]  w_mask;
  logic         w_acc;
  logic         w_start;

  col_parity_vec u_cpv (
    .i_slice (slice_in),
    .o_par   (w_c)
  );

  assign in_ready = (r_state == S_RUN);
  assign w_acc    = in_valid & in_ready;
  assign w_start  = start &
                    ((r_state == S_IDLE) |
                     (r_state == S_DONE));

  always_comb begin
    w_exp = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_exp[bidx(r, c)] = slice_in[bidx(r, c)]
                          ^ w_c[(c + 4) % 5]
                          ^ r_p[(c + 1) % 5];
      end
    end
  end

  assign w_mask = w_exp ^ slice_out;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_acc && r_cnt == LAST)
                 w_next = S_FLUSH;
      S_FLUSH: w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_p       <= '0;
      err_valid <= 1'b0;
      err_mask  <= '0;
      slice_idx <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      r_state   <= w_next;
      err_valid <= w_acc;
      done      <= (r_state == S_FLUSH);
      if (w_start) begin
        r_cnt     <= '0;
        r_p       <= '0;
        err_count <= '0;
        pass      <= 1'b0;
      end else if (w_acc) begin
        r_cnt     <= r_cnt + 6'd1;
        r_p       <= w_c;
        err_mask  <= w_mask;
        slice_idx <= r_cnt;
        if ((|w_mask) && err_count != 7'd127)
          err_count <= err_count + 7'd1;
      end
      // err_count is already final here
      if (r_state == S_FLUSH)
        pass <= (err_count == 7'd0);
    end
  end

endmodule

// File: doc/col_parity_checker.md
COL_PARITY_CHECKER -- requirements
Module: col_parity_checker

Interface
REQ-001 Parameter NUM_SLICES, default 64, number of 25-bit slices per frame (2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begins a frame when in IDLE or DONE.
REQ-005 in_valid  input  1  slice pair present on slice_in/slice_out.
REQ-006 in_ready  output  1  checker accepts a slice pair this cycle.
REQ-007 slice_in  input  25  original slice; bit b = 24-(5*row+col), row/col 0..4.
REQ-008 slice_out  input  25  column-parity-transformed slice under test, same bit layout.
REQ-009 err_valid  output  1  err_mask/slice_idx valid this cycle.
REQ-010 err_mask  output  25  expected XOR slice_out for the checked slice.
REQ-011 slice_idx  output  6  index of the checked slice.
REQ-012 done  output  1  one-cycle pulse when the frame result is final.
REQ-013 pass  output  1  frame had zero mismatching slices; held until next start.
REQ-014 err_count  output  7  number of slices with non-zero err_mask in current frame.

Function
REQ-015 States IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH on acceptance of slice NUM_SLICES-1; FLUSH->DONE after one cycle; DONE->RUN on start.
REQ-016 in_ready SHALL be 1 exactly when state is RUN; acceptance = in_valid & in_ready.
REQ-017 Column parity C[col] = XOR over row 0..4 of slice_in[row,col].
REQ-018 Expected E[row,col] = slice_in[row,col] ^ C[(col+4)%5] ^ P[(col+1)%5], P = C of previously accepted slice of the same frame.
REQ-019 P SHALL be 00000 for slice 0 of every frame (no wrap from last slice).
REQ-020 On acceptance, P register loads current C; slice counter increments.
REQ-021 Latency: err_valid, err_mask, slice_idx registered one cycle after acceptance; err_valid low otherwise.
REQ-022 err_count increments in the same cycle err_valid is asserted with non-zero err_mask; saturates at 127.
REQ-023 done pulses on the DONE entry edge (cycle after FLUSH); pass = (err_count==0) updated same cycle.
REQ-024 start SHALL clear slice counter, P, err_count and pass, and enter RUN next cycle.
REQ-025 start asserted while in RUN or FLUSH SHALL be ignored.
REQ-026 Bubbles (in_valid low in RUN) SHALL hold all state; P is not cleared.

Reset
REQ-027 rst SHALL force IDLE, in_ready=0, err_valid=0, err_mask=0, slice_idx=0, done=0, pass=0, err_count=0, P=0, counter=0.
REQ-028 rst mid-frame SHALL abandon the frame with no done pulse; a new start is required.

Structure
REQ-029 Shared package holds NUM_SLICES default, state encoding, and row/col-to-bit-index constants.
REQ-030 One sub-module col_parity_vec: combinational 25-bit slice -> 5-bit column parity vector, instantiated once.
REQ-031 Expected-slice generation is combinational within the top module; only P, counter, state and outputs are registered.

Verification
REQ-032 NUM_SLICES=64, all slice_in=0, slice_out=0 -> 64 err_valid pulses with err_mask=0, done once, pass=1, err_count=0.
REQ-033 Slice 0 slice_in=0x1000000, slice_out=0x1842108; slice 1 slice_in=0, slice_out=0x0108421; rest zero -> all err_mask=0, pass=1.
REQ-034 As REQ-033 but slice 1 slice_out=0 -> slice_idx=1 err_mask=0x0108421, err_count=1, pass=0.
REQ-035 in_valid toggled 1-0-1 each cycle through a frame -> results identical to REQ-033; done only after 64th acceptance.
REQ-036 rst asserted after 10 accepted slices -> all outputs 0 immediately, no done; subsequent start+frame from REQ-032 passes.
REQ-037 start pulsed during RUN at slice 5 -> ignored; frame completes with correct slice_idx sequence 0..63.
